// File: rtl/baton_beat_scheduler.sv
// Baton beat scheduler: decimated measure strobe, hold-off qualified beats and a valid/ready beat-period port.
// Optional build macro BATON_BEAT_AVG_EN: period_out carries the mean of the last four periods.
module baton_beat_scheduler #(
   parameter int SAMPLE_DIV  = 4,
   parameter int HOLDOFF_CYC = 2000000,
   parameter int MAX_PERIOD  = 50000000,
   parameter int PERIOD_W    = 26
) (
   input  logic                clk_camera_in,
   input  logic                rst_n_in,
   input  logic                enable_in,
   input  logic                frame_done_in,
   input  logic                change_in,
   output logic                measure_out,
   output logic                beat_out,
   output logic [PERIOD_W-1:0] period_out,
   output logic                period_valid_out,
   input  logic                period_ready_in,
   output logic                timeout_out,
   output logic                overrun_out
);

   localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

   typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF, RUN} state_t;

   state_t              state_q, state_d;
   logic [1:0]          rst_sync_q;
   logic [7:0]          div_q, div_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
   logic [PERIOD_W-1:0] pout_q, pout_d;
   logic                pval_q, pval_d;
   logic                beat_q, beat_d;
   logic                meas_q, meas_d;
   logic                tmo_q, tmo_d;
   logic                ovr_q, ovr_d;
   logic                load;
   logic [PERIOD_W-1:0] raw_per;
   logic [PERIOD_W-1:0] per_value;

`ifdef BATON_BEAT_AVG_EN
   logic [PERIOD_W-1:0] hist_q [3];
   logic [PERIOD_W-1:0] hist_d [3];
   logic [1:0]          hcnt_q, hcnt_d;
   logic [PERIOD_W+1:0] sum;
`endif

   // Reset asserts asynchronously; release is held off two clocks so all state leaves reset together.
   always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign raw_per = per_cnt_q + PERIOD_W'(1);

`ifdef BATON_BEAT_AVG_EN
   assign sum       = {2'b00, raw_per} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
   assign per_value = (hcnt_q == 2'd3) ? sum[PERIOD_W+1:2] : raw_per;
`else
   assign per_value = raw_per;
`endif

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      hold_d    = hold_q;
      per_cnt_d = per_cnt_q;
      pout_d    = pout_q;
      pval_d    = pval_q;
      ovr_d     = ovr_q;
      beat_d    = 1'b0;
      meas_d    = 1'b0;
      tmo_d     = 1'b0;
      load      = 1'b0;
`ifdef BATON_BEAT_AVG_EN
      hist_d    = hist_q;
      hcnt_d    = hcnt_q;
`endif
      if (!enable_in) begin
         state_d   = IDLE;
         div_d     = 8'd0;
         hold_d    = '0;
         per_cnt_d = '0;
      end else begin
         if (state_q != IDLE && frame_done_in) begin
            if (div_q == 8'(SAMPLE_DIV - 1)) begin
               div_d  = 8'd0;
               meas_d = 1'b1;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (change_in) begin
                  beat_d    = 1'b1;
                  per_cnt_d = '0;
                  hold_d    = '0;
                  state_d   = HOLDOFF;
               end
            end
            HOLDOFF: begin
               per_cnt_d = per_cnt_q + PERIOD_W'(1);
               hold_d    = hold_q + HOLD_W'(1);
               if (per_cnt_q == PERIOD_W'(MAX_PERIOD - 1)) begin
                  tmo_d     = 1'b1;
                  per_cnt_d = '0;
                  state_d   = ARMED;
               end else if (hold_q == HOLD_W'(HOLDOFF_CYC - 1)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               per_cnt_d = per_cnt_q + PERIOD_W'(1);
               // Timeout takes priority over a coincident direction change.
               if (per_cnt_q == PERIOD_W'(MAX_PERIOD - 1)) begin
                  tmo_d     = 1'b1;
                  per_cnt_d = '0;
                  state_d   = ARMED;
               end else if (change_in) begin
                  beat_d    = 1'b1;
                  load      = 1'b1;
                  per_cnt_d = '0;
                  hold_d    = '0;
                  state_d   = HOLDOFF;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (pval_q && period_ready_in) pval_d = 1'b0;
      if (load) begin
         pout_d = per_value;
         pval_d = 1'b1;
         if (pval_q && !period_ready_in) ovr_d = 1'b1;
`ifdef BATON_BEAT_AVG_EN
         hist_d[0] = raw_per;
         hist_d[1] = hist_q[0];
         hist_d[2] = hist_q[1];
         if (hcnt_q != 2'd3) hcnt_d = hcnt_q + 2'd1;
`endif
      end
`ifdef BATON_BEAT_AVG_EN
      if (state_d == IDLE || state_d == ARMED) hcnt_d = 2'd0;
`endif

      if (!rst_sync_q[1]) begin
         state_d   = IDLE;
         div_d     = 8'd0;
         hold_d    = '0;
         per_cnt_d = '0;
         pout_d    = '0;
         pval_d    = 1'b0;
         ovr_d     = 1'b0;
         beat_d    = 1'b0;
         meas_d    = 1'b0;
         tmo_d     = 1'b0;
`ifdef BATON_BEAT_AVG_EN
         hcnt_d    = 2'd0;
`endif
      end
   end

   always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         div_q     <= 8'd0;
         hold_q    <= '0;
         per_cnt_q <= '0;
         pout_q    <= '0;
         pval_q    <= 1'b0;
         ovr_q     <= 1'b0;
         beat_q    <= 1'b0;
         meas_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         hold_q    <= hold_d;
         per_cnt_q <= per_cnt_d;
         pout_q    <= pout_d;
         pval_q    <= pval_d;
         ovr_q     <= ovr_d;
         beat_q    <= beat_d;
         meas_q    <= meas_d;
         tmo_q     <= tmo_d;
      end
   end

`ifdef BATON_BEAT_AVG_EN
   always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hcnt_q <= 2'd0;
         for (int i = 0; i < 3; i++) hist_q[i] <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         for (int i = 0; i < 3; i++) hist_q[i] <= hist_d[i];
      end
   end
`endif

   assign measure_out      = meas_q;
   assign beat_out         = beat_q;
   assign period_out       = pout_q;
   assign period_valid_out = pval_q;
   assign timeout_out      = tmo_q;
   assign overrun_out      = ovr_q;

endmodule
